// File: rtl/assoc_read_cache.sv
// rtl/assoc_read_cache.sv - set-associative read-only cache with AXI burst line refill
module assoc_read_cache #(
    parameter int LINE_BYTES = 64,
    parameter int SETS       = 64,
    parameter int WAYS       = 2,
    parameter int ADDR_W     = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_data,
    input  logic              invalidate,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    input  logic [63:0]       m_axi_rdata,
    input  logic              m_axi_rlast,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int BEATS  = LINE_BYTES / 8;
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_MISS_REQ, S_REFILL, S_RESPOND
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic [BEAT_W-1:0] beat_q;
    logic              pending_inv;
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAY_W-1:0]  rr_q    [SETS];

    logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
    logic [63:0]       data_mem [SETS][WAYS][BEATS];
    logic [63:0]       line_buf [BEATS];

    logic [IDX_W-1:0]  set_idx;
    logic [TAG_W-1:0]  tag;
    logic [BEAT_W-1:0] word_idx;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  victim;
    logic              set_full;
    logic              fill_done;
    logic [63:0]       hit_word;
    logic [63:0]       fill_word;

    // rlast is deliberately not used: the beat counter alone ends the fill
    logic unused_rlast;
    assign unused_rlast = m_axi_rlast;

    assign set_idx  = addr_q[OFF_W +: IDX_W];
    assign tag      = addr_q[ADDR_W-1 -: TAG_W];
    assign word_idx = addr_q[OFF_W-1:3];

    // Shift the addressed bytes to bit 0 and zero everything above the access size
    function automatic logic [63:0] align_data(input logic [63:0] word,
                                               input logic [2:0]  off,
                                               input logic [1:0]  size);
        logic [63:0] shifted;
        shifted = word >> {off, 3'b000};
        case (size)
            2'd0:    align_data = {56'd0, shifted[7:0]};
            2'd1:    align_data = {48'd0, shifted[15:0]};
            2'd2:    align_data = {32'd0, shifted[31:0]};
            default: align_data = shifted;
        endcase
    endfunction

    // Tag compare across all ways of the addressed set
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[set_idx][w] && (tag_mem[set_idx][w] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: lowest invalid way, else the set's round-robin pointer
    always_comb begin
        victim   = rr_q[set_idx];
        set_full = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[set_idx][w]) begin
                victim   = WAY_W'(w);
                set_full = 1'b0;
            end
        end
    end

    assign fill_done = (state == S_REFILL) && m_axi_rvalid && (beat_q == BEAT_W'(BEATS - 1));
    assign hit_word  = data_mem[set_idx][hit_way][word_idx];
    assign fill_word = (word_idx == BEAT_W'(BEATS - 1)) ? m_axi_rdata : line_buf[word_idx];

    // Next-state selection
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (req_valid && req_ready) state_next = S_LOOKUP;
            S_LOOKUP:   state_next = hit ? S_RESPOND : S_MISS_REQ;
            S_MISS_REQ: if (m_axi_arready) state_next = S_REFILL;
            S_REFILL:   if (fill_done) state_next = S_RESPOND;
            S_RESPOND:  if (resp_ready) state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        req_ready     = (state == S_IDLE) && !invalidate && !reset;
        resp_valid    = (state == S_RESPOND);
        m_axi_arvalid = (state == S_MISS_REQ);
        m_axi_rready  = (state == S_REFILL);
        m_axi_araddr  = '0;
        m_axi_arlen   = '0;
        m_axi_arsize  = '0;
        m_axi_arburst = '0;
        if (state == S_MISS_REQ) begin
            m_axi_araddr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            m_axi_arlen   = 8'(BEATS - 1);
            m_axi_arsize  = 3'd3;
            m_axi_arburst = 2'b01;
        end
    end

    // State register, request capture, cache state, counters and response data
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            addr_q      <= '0;
            size_q      <= '0;
            beat_q      <= '0;
            pending_inv <= 1'b0;
            hit_count   <= '0;
            miss_count  <= '0;
            resp_data   <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state <= state_next;

            if (req_valid && req_ready) begin
                addr_q <= req_addr;
                size_q <= req_size;
            end

            if (state == S_LOOKUP) begin
                if (hit) begin
                    hit_count <= hit_count + 32'd1;
                    resp_data <= align_data(hit_word, addr_q[2:0], size_q);
                end else begin
                    miss_count <= miss_count + 32'd1;
                end
            end

            if ((state == S_REFILL) && m_axi_rvalid) begin
                beat_q <= fill_done ? '0 : beat_q + BEAT_W'(1);
            end

            if (fill_done) begin
                valid_q[set_idx][victim] <= 1'b1;
                if (set_full) begin
                    rr_q[set_idx] <= (rr_q[set_idx] == WAY_W'(WAYS - 1)) ? '0
                                   : rr_q[set_idx] + WAY_W'(1);
                end
                resp_data <= align_data(fill_word, addr_q[2:0], size_q);
            end

            // A flush outside IDLE waits so the in-flight request finishes first
            if ((state == S_IDLE) && (invalidate || pending_inv)) begin
                pending_inv <= 1'b0;
                for (int s = 0; s < SETS; s++) begin
                    valid_q[s] <= '0;
                    rr_q[s]    <= '0;
                end
            end else if (invalidate) begin
                pending_inv <= 1'b1;
            end
        end
    end

    // Line buffer, data and tag arrays carry no reset; validity alone gates use
    always_ff @(posedge clock) begin
        if ((state == S_REFILL) && m_axi_rvalid) begin
            line_buf[beat_q] <= m_axi_rdata;
        end
        if (fill_done) begin
            tag_mem[set_idx][victim] <= tag;
            for (int b = 0; b < BEATS; b++) begin
                data_mem[set_idx][victim][b] <= (b == BEATS - 1) ? m_axi_rdata : line_buf[b];
            end
        end
    end

endmodule

// File: tb/tb_assoc_read_cache.sv
// tb/tb_assoc_read_cache.sv - randomized scoreboard bench for assoc_read_cache
module tb_assoc_read_cache;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic [1:0]  req_size;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        invalidate;
    logic        arvalid;
    logic        arready;
    logic [63:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic [63:0] rdata;
    logic        rlast;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    assoc_read_cache dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_size(req_size),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .invalidate(invalidate),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr),
        .m_axi_arlen(arlen), .m_axi_arsize(arsize), .m_axi_arburst(arburst),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rlast(rlast),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    logic [63:0] exp_ar[$];

    bit          mv  [64][2];
    logic [51:0] mt  [64][2];
    int          mrr [64];
    int          h_cnt = 0;
    int          m_cnt = 0;

    int  ar_delay_cfg  = -1;
    bit  gaps_cfg      = 1'b1;
    int  resp_hold_cfg = 0;
    bit  s_active      = 1'b0;
    int  s_beat        = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Backing memory: line 0x1000 holds 0x11,0x22..0x88; other words are address hashes
    function automatic logic [63:0] mem_word(input logic [63:0] a);
        logic [63:0] line;
        logic [63:0] k;
        line = a & ~64'h3F;
        k    = (a >> 3) & 64'h7;
        if (line == 64'h1000) return 64'h11 * (k + 64'd1);
        return {a[31:0] ^ 32'h5A5A_1234, (a[31:0] * 32'h9E37_79B1) ^ 32'h0BAD_F00D};
    endfunction

    function automatic logic [63:0] exp_data(input logic [63:0] a, input logic [1:0] s);
        logic [63:0] w;
        w = mem_word(a & ~64'h7) >> (8 * a[2:0]);
        if (s != 2'd3) w = w & ((64'd1 << (8 << s)) - 64'd1);
        return w;
    endfunction

    task automatic model_flush();
        for (int s = 0; s < 64; s++) begin
            mv[s][0] = 1'b0;
            mv[s][1] = 1'b0;
            mrr[s]   = 0;
        end
    endtask

    task automatic model_access(input logic [63:0] a, output bit hit);
        int s;
        int v;
        logic [51:0] t;
        s   = int'(a[11:6]);
        t   = a[63:12];
        hit = 1'b0;
        for (int w = 0; w < 2; w++) if (mv[s][w] && mt[s][w] == t) hit = 1'b1;
        if (hit) begin
            h_cnt++;
        end else begin
            m_cnt++;
            v = -1;
            for (int w = 1; w >= 0; w--) if (!mv[s][w]) v = w;
            if (v < 0) begin
                v      = mrr[s];
                mrr[s] = (mrr[s] + 1) % 2;
            end
            mv[s][v] = 1'b1;
            mt[s][v] = t;
        end
    endtask

    task automatic issue_req(input logic [63:0] a, input logic [1:0] s, input bit lat_chk);
        bit hit;
        int n;
        model_access(a, hit);
        exp_q.push_back(exp_data(a, s));
        if (!hit) exp_ar.push_back(a & ~64'h3F);
        @(negedge clock);
        req_valid = 1'b1;
        req_addr  = a;
        req_size  = s;
        #1;
        n = 0;
        while (!req_ready && n < 500) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (!req_ready) check("req_accept_timeout", 64'(n), 64'd0);
        @(negedge clock);
        req_valid = 1'b0;
        if (lat_chk) begin
            check("hit_model_expects_hit", 64'(hit), 64'd1);
            #1 check("hit_lat_cycle1_resp_valid", 64'(resp_valid), 64'd0);
            @(negedge clock);
            #1 check("hit_lat_cycle2_resp_valid", 64'(resp_valid), 64'd1);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        check("resp_outstanding", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clock);
        check("ar_outstanding", 64'(exp_ar.size()), 64'd0);
    endtask

    task automatic do_read(input logic [63:0] a, input logic [1:0] s, input bit lat_chk);
        issue_req(a, s, lat_chk);
        wait_done();
    endtask

    task automatic flush_idle();
        @(negedge clock);
        invalidate = 1'b1;
        #1 check("req_ready_during_invalidate", 64'(req_ready), 64'd0);
        @(negedge clock);
        invalidate = 1'b0;
        model_flush();
    endtask

    // AXI read slave: random arready delay, optional rvalid gaps, AR stability checks
    initial begin : slave
        int ar_wait;
        bit ar_seen;
        logic [63:0] p_addr;
        logic [12:0] p_ctl;
        logic [63:0] s_line;
        logic [63:0] want;
        arready = 1'b0;
        rvalid  = 1'b0;
        rdata   = '0;
        rlast   = 1'b0;
        ar_seen = 1'b0;
        ar_wait = 0;
        s_line  = '0;
        forever begin
            @(negedge clock);
            #1;
            if (reset) begin
                s_active = 1'b0;
                s_beat   = 0;
                ar_seen  = 1'b0;
                arready  = 1'b0;
                rvalid   = 1'b0;
            end else if (!s_active) begin
                rvalid = 1'b0;
                if (arvalid) begin
                    if (ar_seen) begin
                        check("ar_addr_stable", araddr, p_addr);
                        check("ar_ctl_stable", 64'({arlen, arsize, arburst}), 64'(p_ctl));
                    end else begin
                        ar_seen = 1'b1;
                        ar_wait = (ar_delay_cfg >= 0) ? ar_delay_cfg : int'($urandom_range(0, 3));
                        p_addr  = araddr;
                        p_ctl   = {arlen, arsize, arburst};
                    end
                    if (ar_wait == 0) begin
                        arready = 1'b1;
                    end else begin
                        arready = 1'b0;
                        ar_wait--;
                    end
                    if (arready) begin
                        if (exp_ar.size() == 0) begin
                            check("unexpected_ar_araddr", araddr, 64'hFFFF_FFFF_FFFF_FFFF);
                        end else begin
                            want = exp_ar.pop_front();
                            check("ar_araddr", araddr, want);
                        end
                        check("ar_arlen", 64'(arlen), 64'd7);
                        check("ar_arsize", 64'(arsize), 64'd3);
                        check("ar_arburst", 64'(arburst), 64'd1);
                        s_active = 1'b1;
                        s_beat   = 0;
                        s_line   = araddr;
                        ar_seen  = 1'b0;
                    end
                end else begin
                    arready = 1'b0;
                end
            end else begin
                arready = 1'b0;
                rvalid  = gaps_cfg ? ($urandom_range(0, 3) != 0) : 1'b1;
                rdata   = mem_word(s_line + 64'(8 * s_beat));
                rlast   = (s_beat == 7);
                if (rvalid && rready) begin
                    s_beat++;
                    if (s_beat == 8) s_active = 1'b0;
                end
            end
        end
    end

    // Response monitor: drives resp_ready, pops scoreboard on each handshake
    initial begin : monitor
        bit have_prev;
        int hold_cnt;
        logic [63:0] prev_data;
        logic [63:0] want;
        resp_ready = 1'b0;
        have_prev  = 1'b0;
        hold_cnt   = 0;
        prev_data  = '0;
        forever begin
            @(negedge clock);
            #2;
            if (reset) begin
                resp_ready = 1'b0;
                have_prev  = 1'b0;
                hold_cnt   = 0;
            end else if (resp_valid) begin
                if (have_prev) check("resp_data_stable", resp_data, prev_data);
                if (hold_cnt < resp_hold_cfg) begin
                    resp_ready = 1'b0;
                    hold_cnt++;
                end else begin
                    resp_ready = ($urandom_range(0, 3) != 0);
                end
                if (resp_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_resp", resp_data, 64'hDEAD_DEAD_DEAD_DEAD);
                    end else begin
                        want = exp_q.pop_front();
                        check("resp_data", resp_data, want);
                    end
                    have_prev = 1'b0;
                    hold_cnt  = 0;
                end else begin
                    have_prev = 1'b1;
                    prev_data = resp_data;
                end
            end else begin
                resp_ready = 1'b0;
                have_prev  = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #800000;
        check("watchdog_timeout", 64'd1, 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : main
        logic [63:0] a;
        logic [63:0] off;
        logic [1:0]  sz;
        int          hc0;
        int          mc0;
        int          n;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_size   = '0;
        invalidate = 1'b0;
        model_flush();
        repeat (3) @(negedge clock);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_data", resp_data, 64'd0);
        check("rst_arvalid", 64'(arvalid), 64'd0);
        check("rst_rready", 64'(rready), 64'd0);
        check("rst_araddr", araddr, 64'd0);
        check("rst_ar_ctl", 64'({arlen, arsize, arburst}), 64'd0);
        check("rst_hit_count", 64'(hit_count), 64'd0);
        check("rst_miss_count", 64'(miss_count), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        #1 check("req_ready_after_reset", 64'(req_ready), 64'd1);

        // Cold miss then hit in the same line
        do_read(64'h1000, 2'd3, 1'b0);
        check("cold_miss_count", 64'(miss_count), 64'd1);
        do_read(64'h1004, 2'd2, 1'b1);
        check("hit_after_fill_count", 64'(hit_count), 64'd1);

        // Conflict eviction in set 0 from a clean cache
        flush_idle();
        do_read(64'h0000, 2'd3, 1'b0);
        do_read(64'h1000, 2'd3, 1'b0);
        do_read(64'h2000, 2'd3, 1'b0);
        hc0 = int'(hit_count);
        mc0 = int'(miss_count);
        do_read(64'h1000, 2'd3, 1'b0);
        check("conflict_1000_hits", 64'(int'(hit_count) - hc0), 64'd1);
        do_read(64'h0000, 2'd3, 1'b0);
        check("conflict_0000_misses", 64'(int'(miss_count) - mc0), 64'd1);

        // Stalls on AR, R and response
        ar_delay_cfg  = 5;
        resp_hold_cfg = 3;
        do_read(64'h4008, 2'd1, 1'b0);
        ar_delay_cfg  = -1;
        resp_hold_cfg = 0;

        // Invalidate during refill
        issue_req(64'h7010, 2'd2, 1'b0);
        n = 0;
        while (!(s_active && s_beat >= 2) && n < 500) begin
            @(negedge clock);
            #3;
            n++;
        end
        check("refill_reached_for_inv", 64'(s_active && s_beat >= 2), 64'd1);
        invalidate = 1'b1;
        @(negedge clock);
        invalidate = 1'b0;
        model_flush();
        wait_done();
        mc0 = int'(miss_count);
        do_read(64'h7010, 2'd2, 1'b0);
        check("after_inv_refill_misses", 64'(int'(miss_count) - mc0), 64'd1);

        // Randomized traffic over a few conflicting sets
        for (int i = 0; i < 60; i++) begin
            sz  = 2'($urandom_range(0, 3));
            off = 64'($urandom_range(0, 63)) & ~((64'd1 << sz) - 64'd1);
            a   = (64'($urandom_range(0, 3)) << 12) | (64'($urandom_range(0, 3)) << 6) | off;
            resp_hold_cfg = int'($urandom_range(0, 2));
            do_read(a, sz, 1'b0);
            if ($urandom_range(0, 9) == 0) flush_idle();
        end
        resp_hold_cfg = 0;
        check("random_hit_count", 64'(hit_count), 64'(h_cnt));
        check("random_miss_count", 64'(miss_count), 64'(m_cnt));

        // Reset in the middle of a refill
        issue_req(64'h5000, 2'd3, 1'b0);
        n = 0;
        while (!(s_active && s_beat >= 3) && n < 500) begin
            @(negedge clock);
            #3;
            n++;
        end
        check("refill_reached_for_reset", 64'(s_active && s_beat >= 3), 64'd1);
        reset = 1'b1;
        exp_q.delete();
        exp_ar.delete();
        model_flush();
        h_cnt = 0;
        m_cnt = 0;
        @(negedge clock);
        #3;
        check("midfill_rst_arvalid", 64'(arvalid), 64'd0);
        check("midfill_rst_rready", 64'(rready), 64'd0);
        check("midfill_rst_resp_valid", 64'(resp_valid), 64'd0);
        check("midfill_rst_miss_count", 64'(miss_count), 64'd0);
        reset = 1'b0;
        #1 check("midfill_req_ready_after", 64'(req_ready), 64'd1);
        do_read(64'h5000, 2'd3, 1'b0);
        check("after_reset_read_misses", 64'(miss_count), 64'd1);
        check("after_reset_hit_count", 64'(hit_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/assoc_read_cache.md
ASSOC_READ_CACHE -- requirements
Module: assoc_read_cache

Interface
REQ-001 Parameter LINE_BYTES, default 64, meaning line size in bytes; power of two, multiple of 8, at least 16.
REQ-002 Parameter SETS, default 64, meaning number of sets; power of two.
REQ-003 Parameter WAYS, default 2, meaning associativity; power of two, 1..8.
REQ-004 Parameter ADDR_W, default 64, meaning address width; derived BEATS = LINE_BYTES/8, OFF_W = log2(LINE_BYTES), IDX_W = log2(SETS), TAG_W = ADDR_W-IDX_W-OFF_W.
REQ-005 clock  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-006 req_valid  in  1  CPU read request valid; req_ready  out  1  request accepted when both are high.
REQ-007 req_addr  in  ADDR_W  byte address, naturally aligned to req_size; req_size  in  2  log2 bytes (0=1, 1=2, 2=4, 3=8).
REQ-008 resp_valid  out  1  response valid; resp_ready  in  1  response consumed when both are high; resp_data  out  64  zero-extended read data.
REQ-009 invalidate  in  1  single-cycle pulse, flush all lines.
REQ-010 m_axi_arvalid out 1, m_axi_arready in 1, m_axi_araddr out ADDR_W, m_axi_arlen out 8, m_axi_arsize out 3, m_axi_arburst out 2: AXI read-address channel.
REQ-011 m_axi_rvalid in 1, m_axi_rready out 1, m_axi_rdata in 64, m_axi_rlast in 1: AXI read-data channel.
REQ-012 hit_count  out  32, miss_count  out  32  free-running wrap-around counters.

Function
REQ-013 The FSM SHALL have the states IDLE, LOOKUP, MISS_REQ, REFILL and RESPOND, all registered.
REQ-014 In IDLE, req_ready SHALL be 1 and all other states SHALL drive it to 0; an accepted request SHALL register its addr and size and go to LOOKUP.
REQ-015 In LOOKUP, a hit is a valid way in set addr[OFF_W+:IDX_W] whose tag equals addr[ADDR_W-1-:TAG_W]; at most one way hits.
REQ-016 On a hit, the FSM SHALL go to RESPOND and increment hit_count; on a miss, it SHALL go to MISS_REQ and increment miss_count.
REQ-017 Hit latency: resp_valid SHALL rise 2 cycles after the acceptance edge.
REQ-018 In MISS_REQ, the block SHALL drive arvalid=1, araddr = line-aligned address (low OFF_W bits zero), arlen = BEATS-1, arsize = 3 and arburst = 2'b01 (INCR), with all of these stable until arready; the handshake SHALL move the FSM to REFILL.
REQ-019 In REFILL, rready SHALL be 1; beat k (k = 0..BEATS-1) SHALL be written to line word k.
REQ-020 The beat counter SHALL end the fill on beat BEATS-1; rlast is ignored; rvalid gaps SHALL stall the counter.
REQ-021 At the end of the fill, the block SHALL write the line, tag and valid bit into the victim way and go to RESPOND; rready SHALL drop in the following cycle.
REQ-022 Victim selection: the lowest-index invalid way; otherwise the way given by the per-set round-robin pointer, which SHALL advance modulo WAYS only on a fill into a fully valid set.
REQ-023 In RESPOND, resp_valid SHALL be 1 and resp_data SHALL be the addressed bytes shifted to bit 0, with bits at and above 8<<size zeroed; resp_data SHALL be held until resp_ready, then the FSM SHALL go to IDLE.
REQ-024 Back-to-back requests: the next request SHALL be acceptable in the cycle after the resp handshake.
REQ-025 An invalidate pulse in IDLE SHALL clear all valid bits and round-robin pointers at that edge, and req_ready SHALL be 0 in that cycle.
REQ-026 An invalidate pulse in any other state SHALL be latched and applied on the first IDLE cycle; the in-flight request SHALL still complete, and the refilled line SHALL be cleared by the pending flush.
REQ-027 Data arrays SHALL need no reset; valid bits SHALL be the only cache-state reset.

Reset
REQ-028 Reset SHALL force IDLE, clear all valid bits, round-robin pointers, the pending-invalidate flag, the beat counter, hit_count and miss_count.
REQ-029 Reset values SHALL be: req_ready=0 during reset and 1 in the cycle after; resp_valid=0; resp_data=0; arvalid=0; rready=0; araddr=0; arlen=0; arsize=0; arburst=0.
REQ-030 Reset mid-refill SHALL abandon the burst; the interconnect is reset together with the block, and no partial line SHALL become valid.

Verification
REQ-031 Cold miss: read 0x1000 size 3 -> araddr=0x1000, arlen=7, arsize=3, arburst=1; beats 0x11..0x88 -> resp_data=beat0 value; miss_count=1.
REQ-032 Hit after fill: read 0x1004 size 2 -> resp_valid 2 cycles after acceptance, resp_data=beat0[63:32] zero-extended; no AR activity; hit_count=1.
REQ-033 Conflict (WAYS=2, SETS=64, LINE=64): fill 0x0000, 0x1000, 0x2000 -> the third fill evicts way 0 (0x0000); re-reading 0x0000 misses and 0x1000 hits.
REQ-034 Stalls: arready delayed 5 cycles, rvalid gaps, resp_ready held low 3 cycles -> AR signals stable, resp_data stable, one response per request.
REQ-035 Invalidate during REFILL -> the current response is still correct; the next read of the same line misses.
REQ-036 Reset asserted at REFILL beat 3 -> arvalid=rready=resp_valid=0; a subsequent read of the same address misses.
